uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 29 ++
 rtl/rr_priority_select.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   UART_DATA_W : byte width on the TxUart data path
//   GRANT_ID_W  : width of requester indices and the grantId port
//   arb_state_e : arbiter FSM state encoding
//   rr_distance : circular distance from the round-robin pointer to an index
//   rr_next     : (cur + 1) mod n
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned GRANT_ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_distance(input int unsigned idx,
                                              input int unsigned ptr,
                                              input int unsigned n);
    return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
  endfunction

  function automatic logic [GRANT_ID_W-1:0] rr_next(input logic [GRANT_ID_W-1:0] cur,
                                                    input int unsigned n);
    if (32'(cur) + 32'd1 >= n) return '0;
    return cur + GRANT_ID_W'(1);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Circular first-valid search.
//   req_i   : request vector, N bits
//   ptr_i   : search start index (must be < N)
//   idx_o   : first index at or after ptr_i (wrapping) with req_i set
//   found_o : high when any request bit is set
module rr_priority_select
  import uart_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            req_i,
  input  logic [GRANT_ID_W-1:0]   ptr_i,
  output logic [GRANT_ID_W-1:0]   idx_o,
  output logic                    found_o
);

  int unsigned bestDist;

  // The nearest set bit going forward from the pointer wins.
  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    bestDist = N;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && (rr_distance(i, 32'(ptr_i), N) < bestDist)) begin
        bestDist = rr_distance(i, 32'(ptr_i), N);
        idx_o    = GRANT_ID_W'(i);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one TxUart among NUM_REQ requesters.
// A grant lasts until the owner's last byte or until the owner has been
// starved for TIMEOUT cycles; every grant ends with at least one IDLE cycle.
//   clk, rst          : clock, synchronous active-high reset
//   reqValid/reqData/reqLast/reqReady : per-requester byte handshake
//   txFull            : TxUart FIFO full (back-pressure)
//   dataIn, write     : byte and strobe to the TxUart
//   grantId, busy     : current owner and grant-active flag
//   timeoutErr        : one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             reqValid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]             reqLast,
  output logic [NUM_REQ-1:0]             reqReady,
  input  logic                           txFull,
  output logic [UART_DATA_W-1:0]         dataIn,
  output logic                           write,
  output logic [GRANT_ID_W-1:0]          grantId,
  output logic                           busy,
  output logic                           timeoutErr
);

  arb_state_e              state_q;
  logic [GRANT_ID_W-1:0]   owner_q;
  logic [GRANT_ID_W-1:0]   rrPtr_q;
  logic [15:0]             idleCnt_q;
  logic [15:0]             idleCnt_d;
  logic                    timeoutErr_q;

  logic                    ownValid;
  logic                    ownLast;
  logic [UART_DATA_W-1:0]  ownData;
  logic [GRANT_ID_W-1:0]   selIdx;
  logic                    selFound;
  logic                    inGrant;
  logic                    xfer;
  logic                    starved;
  logic                    timeoutHit;
  logic [GRANT_ID_W-1:0]   nextPtr;

  rr_priority_select #(
    .N (NUM_REQ)
  ) u_sel (
    .req_i   (reqValid),
    .ptr_i   (rrPtr_q),
    .idx_o   (selIdx),
    .found_o (selFound)
  );

  // Owner's handshake signals, selected by comparison so no index wider
  // than the vector is ever used.
  always_comb begin
    ownValid = 1'b0;
    ownLast  = 1'b0;
    ownData  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == GRANT_ID_W'(i)) begin
        ownValid = reqValid[i];
        ownLast  = reqLast[i];
        ownData  = reqData[UART_DATA_W*i +: UART_DATA_W];
      end
    end
  end

  // Gating with rst keeps a reset cycle from accepting a byte of the
  // packet being abandoned.
  assign inGrant = (state_q == GRANT) && !rst;

  always_comb begin
    reqReady = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      reqReady[i] = inGrant && (owner_q == GRANT_ID_W'(i)) && !txFull;
    end
  end

  assign xfer       = inGrant && !txFull && ownValid;
  assign write      = xfer;
  assign dataIn     = xfer ? ownData : '0;
  assign busy       = (state_q == GRANT);
  assign grantId    = busy ? owner_q : '0;
  assign timeoutErr = timeoutErr_q;
  assign nextPtr    = rr_next(owner_q, NUM_REQ);

  // Only cycles where the owner has nothing to offer count as idle;
  // back-pressure from the TxUart freezes the count.
  assign starved = !txFull && !ownValid;

  always_comb begin
    idleCnt_d = idleCnt_q;
    if (xfer) begin
      idleCnt_d = '0;
    end else if (starved && (idleCnt_q != '1)) begin
      idleCnt_d = idleCnt_q + 16'd1;
    end
  end

  assign timeoutHit = starved && (32'(idleCnt_d) >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rrPtr_q      <= '0;
      idleCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      timeoutErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (selFound) begin
            owner_q   <= selIdx;
            idleCnt_q <= '0;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          idleCnt_q <= idleCnt_d;
          if (xfer && ownLast) begin
            state_q <= IDLE;
            rrPtr_q <= nextPtr;
          end else if (timeoutHit) begin
            state_q      <= IDLE;
            rrPtr_q      <= nextPtr;
            idleCnt_q    <= '0;
            timeoutErr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
